// File: rtl/mem_arbiter.sv
// Single-port RAM arbiter between instruction fetch and data access, with
// bounded data priority, one access at a time and a per-access watchdog.
module mem_arbiter #(
    parameter int TIMEOUT    = 64,
    parameter int STARVE_MAX = 3
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        iREN,
    input  logic [31:0] iaddr,
    output logic        iwait,
    output logic [31:0] iload,
    input  logic        dREN,
    input  logic        dWEN,
    input  logic [31:0] daddr,
    input  logic [31:0] dstore,
    output logic        dwait,
    output logic [31:0] dload,
    output logic        ramREN,
    output logic        ramWEN,
    output logic [31:0] ramaddr,
    output logic [31:0] ramstore,
    input  logic [31:0] ramload,
    input  logic        ram_ready,
    output logic        err
);

    localparam int TW = $clog2(TIMEOUT + 1);
    localparam int SW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
    localparam logic [31:0] ABORT_WORD = 32'hBAD1BAD1;

    typedef enum logic [2:0] {IDLE, DBUSY, IBUSY, DDONE, IDONE} state_t;

    state_t        state;
    logic [TW-1:0] tcnt;
    logic [SW-1:0] starve;
    logic          dreq;
    logic          starved;
    logic          tmo;

    function automatic logic [SW-1:0] starve_inc(input logic [SW-1:0] c);
        return (c == SW'(STARVE_MAX)) ? c : c + SW'(1);
    endfunction

    assign dreq    = dREN | dWEN;
    // Data normally wins, unless the fetch side has already lost STARVE_MAX times in a row.
    assign starved = iREN && (starve == SW'(STARVE_MAX));
    assign tmo     = (tcnt == TW'(TIMEOUT - 1));

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            state    <= IDLE;
            ramREN   <= 1'b0;
            ramWEN   <= 1'b0;
            ramaddr  <= '0;
            ramstore <= '0;
            iload    <= '0;
            dload    <= '0;
            iwait    <= 1'b1;
            dwait    <= 1'b1;
            err      <= 1'b0;
            tcnt     <= '0;
            starve   <= '0;
        end else begin
            iwait <= 1'b1;
            dwait <= 1'b1;
            case (state)
                IDLE: begin
                    if (dreq && !starved) begin
                        state    <= DBUSY;
                        ramaddr  <= daddr;
                        ramstore <= dstore;
                        ramWEN   <= dWEN;
                        ramREN   <= !dWEN;
                        tcnt     <= '0;
                        starve   <= iREN ? starve_inc(starve) : '0;
                    end else if (iREN) begin
                        state   <= IBUSY;
                        ramaddr <= iaddr;
                        ramREN  <= 1'b1;
                        tcnt    <= '0;
                        starve  <= '0;
                    end
                end
                DBUSY, IBUSY: begin
                    if (ram_ready || tmo) begin
                        ramREN <= 1'b0;
                        ramWEN <= 1'b0;
                        // An aborted access still completes towards the requester, with a marker word.
                        if (!ram_ready) err <= 1'b1;
                        if (state == DBUSY) begin
                            dload <= ram_ready ? ramload : ABORT_WORD;
                            dwait <= 1'b0;
                            state <= DDONE;
                        end else begin
                            iload <= ram_ready ? ramload : ABORT_WORD;
                            iwait <= 1'b0;
                            state <= IDONE;
                        end
                    end else begin
                        tcnt <= tcnt + TW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized bench for mem_arbiter: requester and RAM models plus a
// transaction-timeline reference that predicts every cycle's outputs.
module tb_mem_arbiter;

    localparam int TIMEOUT    = 8;
    localparam int STARVE_MAX = 2;
    localparam logic [31:0] BAD = 32'hBAD1BAD1;
    localparam int BIG = 32'h7fffffff;

    logic        CLK = 1'b0;
    logic        nRST = 1'b0;
    logic        iREN = 1'b0;
    logic [31:0] iaddr = '0;
    logic        iwait;
    logic [31:0] iload;
    logic        dREN = 1'b0;
    logic        dWEN = 1'b0;
    logic [31:0] daddr = '0;
    logic [31:0] dstore = '0;
    logic        dwait;
    logic [31:0] dload;
    logic        ramREN;
    logic        ramWEN;
    logic [31:0] ramaddr;
    logic [31:0] ramstore;
    logic [31:0] ramload = '0;
    logic        ram_ready = 1'b0;
    logic        err;

    always #5 CLK = ~CLK;

    mem_arbiter #(.TIMEOUT(TIMEOUT), .STARVE_MAX(STARVE_MAX)) dut (
        .CLK(CLK), .nRST(nRST),
        .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
        .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
        .dwait(dwait), .dload(dload),
        .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
        .ramload(ramload), .ram_ready(ram_ready), .err(err)
    );

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    // reference timeline state
    bit          armed = 0, rst_req = 0, rst_chk = 0;
    bit          act = 0, t_d, t_wr, t_tmo;
    int          ta, tb, tlat, arb_at = 0, starve_m = 0, err_from = BIG;
    logic [31:0] t_addr, t_data, t_exp;
    logic [31:0] ram_mem [logic [31:0]];
    logic [31:0] ref_mem [logic [31:0]];

    // requesters and knobs
    bit          i_pend = 0, i_ghost = 0, d_pend = 0, d_ghost = 0, d_wr = 0, d_both = 0;
    logic [31:0] i_addr = '0, d_addr = '0, d_data = '0;
    int          i_prob = 0, d_prob = 0, wr_prob = 0, never_prob = 0, abandon_prob = 0;
    int          fixed_lat = -1;
    bit          prev_strobe = 0;
    logic [31:0] rise_addr [$];

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [31:0] init_word(input logic [31:0] a);
        return a ^ 32'h5A5A_0000 ^ (a << 16);
    endfunction

    function automatic logic [31:0] ref_read(input logic [31:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : init_word(a);
    endfunction

    task automatic check_outputs();
        bit exp_ren, exp_wen, exp_iw, exp_dw;
        if (rst_chk) begin
            check_val("rst_ramREN", 32'(ramREN), 32'd0);
            check_val("rst_ramWEN", 32'(ramWEN), 32'd0);
            check_val("rst_ramaddr", ramaddr, 32'd0);
            check_val("rst_ramstore", ramstore, 32'd0);
            check_val("rst_iload", iload, 32'd0);
            check_val("rst_dload", dload, 32'd0);
            check_val("rst_iwait", 32'(iwait), 32'd1);
            check_val("rst_dwait", 32'(dwait), 32'd1);
            check_val("rst_err", 32'(err), 32'd0);
        end else if (armed) begin
            exp_ren = 0; exp_wen = 0; exp_iw = 1; exp_dw = 1;
            if (act && cyc > ta && cyc <= ta + tb) begin
                exp_wen = t_d && t_wr;
                exp_ren = !(t_d && t_wr);
                check_val("ramaddr", ramaddr, t_addr);
                if (t_d) check_val("ramstore", ramstore, t_data);
            end else if (act && cyc == ta + tb + 1) begin
                if (t_d) begin
                    exp_dw = 0;
                    if (!t_wr || t_tmo) check_val("dload", dload, t_exp);
                end else begin
                    exp_iw = 0;
                    check_val("iload", iload, t_exp);
                end
                act = 0;
            end
            check_val("ramREN", 32'(ramREN), 32'(exp_ren));
            check_val("ramWEN", 32'(ramWEN), 32'(exp_wen));
            check_val("iwait", 32'(iwait), 32'(exp_iw));
            check_val("dwait", 32'(dwait), 32'(exp_dw));
            check_val("err", 32'(err), 32'(cyc >= err_from));
        end
        if ((ramREN | ramWEN) === 1'b1 && !prev_strobe) rise_addr.push_back(ramaddr);
        prev_strobe = ((ramREN | ramWEN) === 1'b1);
    endtask

    // Winner and timeline of the next access, decided from the requests seen while free.
    task automatic arbitrate();
        bit dq, iq;
        dq = dREN | dWEN;
        iq = iREN;
        if (dq && !(iq && starve_m == STARVE_MAX)) begin
            t_d = 1; t_wr = d_wr; t_addr = d_addr; t_data = d_data;
            starve_m = iq ? starve_m + 1 : 0;
        end else if (iq) begin
            t_d = 0; t_wr = 0; t_addr = i_addr; t_data = '0;
            starve_m = 0;
        end else begin
            arb_at = cyc + 1;
            return;
        end
        if (fixed_lat >= 0) tlat = fixed_lat;
        else tlat = (int'($urandom_range(99)) < never_prob) ? 0 : int'($urandom_range(4, 1));
        t_tmo = (tlat == 0 || tlat > TIMEOUT);
        tb = t_tmo ? TIMEOUT : tlat;
        if (t_tmo) tlat = 0;
        ta = cyc;
        act = 1;
        arb_at = ta + tb + 2;
        if (t_tmo) begin
            t_exp = BAD;
            if (ta + tb + 1 < err_from) err_from = ta + tb + 1;
        end else if (t_d && t_wr) begin
            ref_mem[t_addr] = t_data;
            t_exp = '0;
        end else begin
            t_exp = ref_read(t_addr);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
        cyc++;
        check_outputs();
        if (iwait === 1'b0) begin if (i_ghost) i_ghost = 0; else i_pend = 0; end
        if (dwait === 1'b0) begin if (d_ghost) d_ghost = 0; else d_pend = 0; end
        if (act && cyc > ta && cyc <= ta + tb && int'($urandom_range(99)) < abandon_prob) begin
            if (t_d && d_pend) begin d_pend = 0; d_ghost = 1; end
            else if (!t_d && i_pend) begin i_pend = 0; i_ghost = 1; end
        end
        if (!i_pend && !i_ghost && int'($urandom_range(99)) < i_prob) begin
            i_pend = 1;
            i_addr = 32'($urandom_range(63)) << 2;
        end
        if (!d_pend && !d_ghost && int'($urandom_range(99)) < d_prob) begin
            d_pend = 1;
            d_addr = 32'h1000 + (32'($urandom_range(63)) << 2);
            d_data = $urandom;
            d_wr   = int'($urandom_range(99)) < wr_prob;
            d_both = $urandom_range(1) == 1;
        end
        nRST   = !rst_req;
        iREN   = i_pend;
        iaddr  = i_addr;
        dREN   = d_pend && (!d_wr || d_both);
        dWEN   = d_pend && d_wr;
        daddr  = d_addr;
        dstore = d_data;
        ram_ready = 1'b0;
        ramload   = $urandom;
        if (!rst_req && act && tlat != 0 && cyc == ta + tlat) begin
            ram_ready = 1'b1;
            if (ramWEN === 1'b1) ram_mem[ramaddr] = ramstore;
            ramload = ram_mem.exists(ramaddr) ? ram_mem[ramaddr] : init_word(ramaddr);
        end
        if (rst_req) begin
            act = 0; arb_at = cyc + 1; starve_m = 0; err_from = BIG;
            rst_chk = 1; armed = 1; i_ghost = 0; d_ghost = 0;
        end else begin
            rst_chk = 0;
            if (armed && cyc == arb_at) arbitrate();
        end
    endtask

    task automatic run_until_idle(input int maxc);
        int n = 0;
        while ((i_pend || d_pend || i_ghost || d_ghost || act) && n < maxc) begin
            step();
            n++;
        end
        check_val("idle_wait", 32'(n < maxc), 32'd1);
    endtask

    task automatic run_random(input int n);
        for (int k = 0; k < n; k++) step();
    endtask

    initial begin
        // reset held two cycles with both requests pending
        i_pend = 1; i_addr = 32'h20;
        d_pend = 1; d_wr = 1; d_addr = 32'h1010; d_data = 32'h1234_5678;
        rst_req = 1;
        step(); step();
        rst_req = 0;
        run_until_idle(100);

        // single instruction read, RAM answers 3 cycles after the strobe rises
        fixed_lat = 4;
        ram_mem[32'h40] = 32'h8C220004;
        ref_mem[32'h40] = 32'h8C220004;
        i_pend = 1; i_addr = 32'h40;
        run_until_idle(100);
        check_val("t2_iload", iload, 32'h8C220004);

        // simultaneous write and fetch
        fixed_lat = -1;
        rise_addr.delete();
        d_pend = 1; d_wr = 1; d_both = 0; d_addr = 32'h100; d_data = 32'hDEADBEEF;
        i_pend = 1; i_addr = 32'h44;
        run_until_idle(100);
        check_val("t3_nacc", 32'(rise_addr.size()), 32'd2);
        check_val("t3_first", (rise_addr.size() > 0) ? rise_addr[0] : 32'hFFFF_FFFF, 32'h100);
        check_val("t3_second", (rise_addr.size() > 1) ? rise_addr[1] : 32'hFFFF_FFFF, 32'h44);
        check_val("t3_ramwrite", ram_mem.exists(32'h100) ? ram_mem[32'h100] : 32'h0, 32'hDEADBEEF);

        // starvation bound with both sides always requesting
        rst_req = 1; step(); rst_req = 0;
        rise_addr.delete();
        i_prob = 100; d_prob = 100; wr_prob = 0; fixed_lat = 1;
        for (int k = 0; k < 200 && rise_addr.size() < 6; k++) step();
        i_prob = 0; d_prob = 0;
        run_until_idle(100);
        begin
            bit exp_d [6] = '{1, 1, 0, 1, 1, 0};
            for (int k = 0; k < 6; k++)
                check_val($sformatf("t4_grant%0d_is_d", k),
                          (rise_addr.size() > k) ? 32'(rise_addr[k] >= 32'h1000) : 32'hFFFF_FFFF,
                          32'(exp_d[k]));
        end

        // watchdog abort, then err must persist across normal traffic
        fixed_lat = 0;
        d_pend = 1; d_wr = 0; d_both = 0; d_addr = 32'h1040;
        run_until_idle(100);
        check_val("t5_err", 32'(err), 32'd1);
        check_val("t5_dload", dload, BAD);
        fixed_lat = -1;
        i_prob = 30; d_prob = 30; wr_prob = 40; never_prob = 5; abandon_prob = 3;
        run_random(1500);
        i_prob = 0; d_prob = 0;
        run_until_idle(200);
        check_val("t5_err_sticky", 32'(err), 32'd1);

        // reset while a fetch is in flight, then a fresh fetch
        abandon_prob = 0; fixed_lat = 0;
        i_pend = 1; i_addr = 32'h80;
        for (int k = 0; k < 50 && !(act && cyc >= ta + 3); k++) step();
        check_val("t6_in_flight", 32'(act), 32'd1);
        rst_req = 1; step(); rst_req = 0;
        fixed_lat = 2;
        i_addr = 32'h84;
        run_until_idle(100);
        check_val("t6_iload", iload, ref_read(32'h84));
        check_val("t6_err", 32'(err), 32'd0);

        // second random phase from a clean error state
        fixed_lat = -1;
        i_prob = 40; d_prob = 40; wr_prob = 50; never_prob = 3; abandon_prob = 3;
        run_random(1500);
        i_prob = 0; d_prob = 0;
        run_until_idle(200);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
